// File: rtl/tow_push_arbiter.sv
// Referee for two pushbuttons: first-edge arbitration, false-start and idle-timeout detection.
// Latency: edge at cycle n -> push/flags at n+1; no backpressure, results held until clear.
module tow_push_arbiter #(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic pbl,
  input  logic pbr,
  input  logic leds_on,
  input  logic clear,
  input  logic slowen,
  output logic push,
  output logic right,
  output logic tie,
  output logic fault,
  output logic decided
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);

  state_t               state;
  state_t               state_nxt;
  logic [TIMEOUT_W-1:0] cnt;
  logic [TIMEOUT_W-1:0] cnt_nxt;
  logic                 pbl_q;
  logic                 pbr_q;
  logic                 edge_l;
  logic                 edge_r;
  logic                 push_nxt;
  logic                 right_nxt;
  logic                 tie_nxt;
  logic                 fault_nxt;

  assign edge_l = pbl & ~pbl_q;
  assign edge_r = pbr & ~pbr_q;

  // Previous-level registers keep tracking during reset so a held button never looks like an edge.
  always_ff @(posedge clk) begin
    pbl_q <= pbl;
    pbr_q <= pbr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      push    <= 1'b0;
      right   <= 1'b0;
      tie     <= 1'b0;
      fault   <= 1'b0;
      decided <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      push    <= push_nxt;
      right   <= right_nxt;
      tie     <= tie_nxt;
      fault   <= fault_nxt;
      decided <= (state_nxt == ST_DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    push_nxt  = 1'b0;
    right_nxt = right;
    tie_nxt   = tie;
    fault_nxt = fault;

    if (clear) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      right_nxt = 1'b0;
      tie_nxt   = 1'b0;
      fault_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Any edge before the window is open is a false start; the other player wins.
          if (edge_l | edge_r) begin
            state_nxt = ST_DONE;
            push_nxt  = 1'b1;
            fault_nxt = 1'b1;
            right_nxt = edge_l & ~edge_r;
            tie_nxt   = edge_l & edge_r;
          end else if (leds_on) begin
            state_nxt = ST_ARMED;
            cnt_nxt   = '0;
          end
        end

        ST_ARMED: begin
          if (edge_l | edge_r) begin
            state_nxt = ST_DONE;
            push_nxt  = 1'b1;
            fault_nxt = 1'b0;
            right_nxt = edge_r & ~edge_l;
            tie_nxt   = edge_l & edge_r;
          end else if (!leds_on) begin
            state_nxt = ST_IDLE;
          end else if (slowen) begin
            if (cnt == CNT_LAST) begin
              state_nxt = ST_DONE;
              push_nxt  = 1'b1;
              fault_nxt = 1'b0;
              right_nxt = 1'b0;
              tie_nxt   = 1'b1;
            end else begin
              cnt_nxt = cnt + TIMEOUT_W'(1);
            end
          end
        end

        ST_DONE: begin
          state_nxt = ST_DONE;
        end

        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tow_push_arbiter.sv
// Directed bench: stimulus queues expected push results; a negedge monitor checks each push.
module tb_tow_push_arbiter;

  logic clk = 1'b0;
  logic rst, pbl, pbr, leds_on, clear, slowen;
  logic push, right, tie, fault, decided;

  typedef struct {
    logic r;
    logic t;
    logic f;
    int   due;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_cnt = 0;

  tow_push_arbiter #(.TIMEOUT_W(8), .TIMEOUT(3)) dut (
    .clk(clk), .rst(rst), .pbl(pbl), .pbr(pbr), .leds_on(leds_on),
    .clear(clear), .slowen(slowen), .push(push), .right(right),
    .tie(tie), .fault(fault), .decided(decided)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (push) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_push cyc=%0d r=%0b t=%0b f=%0b", cyc_cnt, right, tie, fault);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (right !== e.r || tie !== e.t || fault !== e.f || decided !== 1'b1 || cyc_cnt != e.due) begin
          errors++;
          $display("FAIL push_result act r=%0b t=%0b f=%0b d=%0b cyc=%0d exp r=%0b t=%0b f=%0b d=1 cyc=%0d",
                   right, tie, fault, decided, cyc_cnt, e.r, e.t, e.f, e.due);
        end
      end
    end
  end

  task automatic expect_push(input logic r, input logic t, input logic f);
    exp_t e;
    e.r = r;
    e.t = t;
    e.f = f;
    e.due = cyc_cnt + 1;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // {push, right, tie, fault, decided}
  function automatic logic [31:0] outs();
    return {27'd0, push, right, tie, fault, decided};
  endfunction

  initial begin
    rst = 1'b1; pbl = 1'b0; pbr = 1'b0; leds_on = 1'b0; clear = 1'b0; slowen = 1'b0;
    cyc(3);
    chk("reset_outputs", outs(), 32'b00000);

    // Right wins after the window opens
    rst = 1'b0; leds_on = 1'b1;
    cyc(5);
    pbr = 1'b1; expect_push(1'b1, 1'b0, 1'b0);
    cyc(2);
    chk("right_win_held", outs(), 32'b01001);
    cyc(3);
    chk("right_win_still_held", outs(), 32'b01001);
    clear = 1'b1; pbr = 1'b0;
    cyc(1);
    clear = 1'b0;
    chk("right_win_cleared", outs(), 32'b00000);

    // Simultaneous press while armed
    cyc(1);
    pbl = 1'b1; pbr = 1'b1; expect_push(1'b0, 1'b1, 1'b0);
    cyc(2);
    chk("tie_held", outs(), 32'b00101);
    clear = 1'b1; pbl = 1'b0; pbr = 1'b0; leds_on = 1'b0;
    cyc(1);
    clear = 1'b0;
    chk("tie_cleared", outs(), 32'b00000);

    // False start by left, then DONE ignores everything
    cyc(1);
    pbl = 1'b1; expect_push(1'b1, 1'b0, 1'b1);
    cyc(1);
    leds_on = 1'b1; pbl = 1'b0; pbr = 1'b1;
    cyc(1);
    pbr = 1'b0; pbl = 1'b1; slowen = 1'b1;
    cyc(1);
    pbl = 1'b0; slowen = 1'b0;
    cyc(2);
    chk("false_start_frozen", outs(), 32'b01011);
    clear = 1'b1; leds_on = 1'b0;
    cyc(1);
    clear = 1'b0;
    chk("false_start_cleared", outs(), 32'b00000);

    // Left held through reset into ARMED, then right presses
    rst = 1'b1; pbl = 1'b1;
    cyc(2);
    rst = 1'b0; leds_on = 1'b1;
    cyc(4);
    chk("held_button_no_decision", outs(), 32'b00000);
    pbr = 1'b1; expect_push(1'b1, 1'b0, 1'b0);
    cyc(2);
    chk("held_button_right_wins", outs(), 32'b01001);
    clear = 1'b1; pbl = 1'b0; pbr = 1'b0; leds_on = 1'b0;
    cyc(1);
    clear = 1'b0;

    // Timeout after the third slowen tick
    leds_on = 1'b1;
    cyc(1);
    for (int i = 0; i < 2; i++) begin
      slowen = 1'b1; cyc(1);
      slowen = 1'b0; cyc(1);
    end
    chk("timeout_two_ticks_pending", outs(), 32'b00000);
    slowen = 1'b1; expect_push(1'b0, 1'b1, 1'b0);
    cyc(1);
    slowen = 1'b0;
    cyc(1);
    chk("timeout_tie", outs(), 32'b00101);
    clear = 1'b1; leds_on = 1'b0;
    cyc(1);
    clear = 1'b0;

    // Window closes before the third tick; re-arming restarts the count
    leds_on = 1'b1;
    cyc(1);
    for (int i = 0; i < 2; i++) begin
      slowen = 1'b1; cyc(1);
      slowen = 1'b0; cyc(1);
    end
    leds_on = 1'b0;
    cyc(1);
    slowen = 1'b1; cyc(1);
    slowen = 1'b0; cyc(1);
    chk("leds_fall_back_to_idle", outs(), 32'b00000);
    leds_on = 1'b1;
    cyc(1);
    for (int i = 0; i < 2; i++) begin
      slowen = 1'b1; cyc(1);
      slowen = 1'b0; cyc(1);
    end
    chk("rearm_count_restarts", outs(), 32'b00000);
    leds_on = 1'b0;
    cyc(1);

    // Clear collides with a winning edge; the next-cycle edge is judged from IDLE
    leds_on = 1'b1;
    cyc(1);
    pbr = 1'b1; clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("clear_collision", outs(), 32'b00000);
    pbl = 1'b1; expect_push(1'b1, 1'b0, 1'b1);
    cyc(2);
    chk("after_collision_false_start", outs(), 32'b01011);

    // Reset from DONE
    rst = 1'b1;
    cyc(1);
    rst = 1'b0; pbl = 1'b0; pbr = 1'b0; leds_on = 1'b0;
    chk("reset_from_done", outs(), 32'b00000);

    cyc(3);
    chk("pending_pushes", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tow_push_arbiter.md
# tow_push_arbiter

Clocked referee between the two player pushbuttons and the round controller. Each round it decides the winner (left, right or tie), detects false starts before the LEDs light, and times out idle rounds. It then reports one registered `push` pulse with held result flags to the scorer and opponent logic. It replaces asynchronous first-press latching with a deterministic, single-clock arbitration in front of the scorer path.

## Interface
Parameters:
- `TIMEOUT_W`, default 8: width of the round-timeout counter.
- `TIMEOUT`, default 200: number of `slowen` ticks in ARMED before a forced tie; legal range 1 to 2^TIMEOUT_W-1.

Ports:
- `clk`  input  1  system clock; single clock domain.
- `rst`  input  1  reset, synchronous, active-high.
- `pbl`  input  1  left button level, already synchronized to `clk`; 1 = pressed.
- `pbr`  input  1  right button level, already synchronized to `clk`; 1 = pressed.
- `leds_on`  input  1  level from round controller; 1 = go window open.
- `clear`  input  1  one-cycle round-clear pulse from round controller.
- `slowen`  input  1  one-cycle tick enable from the clock divider.
- `push`  output  1  one-cycle pulse: round decided.
- `right`  output  1  winner is right (0 = left); valid from `push`, held until clear or reset.
- `tie`  output  1  round tied; valid from `push`, held until clear or reset.
- `fault`  output  1  decision caused by a false start; held until clear or reset.
- `decided`  output  1  level; 1 while in DONE.

## Operation
- **Edge detection.** Registered `pbl_q`/`pbr_q` hold the previous level. An edge is `pbX & ~pbX_q`. Only edges count, so held buttons never win.
- **States.** IDLE, ARMED and DONE. The state register and all outputs are registered.
- **IDLE, `leds_on` = 0.**
  - Left edge only: false start by left. Go to DONE with `right`=1, `fault`=1.
  - Right edge only: go to DONE with `right`=0, `fault`=1.
  - Both edges in the same cycle: go to DONE with `tie`=1, `fault`=1.
  - Otherwise, when `leds_on` = 1: go to ARMED, timeout counter = 0.
- **ARMED.**
  - Left edge only: DONE, `right`=0.
  - Right edge only: DONE, `right`=1.
  - Both edges in the same cycle: DONE, `tie`=1.
  - Button edges take priority over `leds_on` falling and over timeout in the same cycle.
  - `leds_on` = 0 with no edge: return to IDLE, no `push`.
  - On each `slowen`, the counter increments. When the counter equals TIMEOUT-1 and `slowen` = 1, go to DONE with `tie`=1, `fault`=0.
- **DONE.**
  - Results are frozen. Buttons, `leds_on` and `slowen` are ignored.
  - Stays in DONE until `clear`.
- **Priority.** `rst` > `clear` > arbitration. `clear` in any state, including the decision cycle, forces IDLE, zeroes `right`/`tie`/`fault`/`decided`/counter and suppresses `push`.
- **Reset.** State IDLE. `push`, `right`, `tie`, `fault`, `decided` and counter are 0. `pbl_q`/`pbr_q` load the current `pbl`/`pbr` during reset, so a button held through reset produces no edge.
- **Counter.** TIMEOUT_W bits, no wrap: it cannot pass TIMEOUT-1 because the timeout transition leaves ARMED.

## Timing
- **Decision latency.**
  - Button edge visible at cycle n: `push`, `right`/`tie`/`fault` and `decided` are high at cycle n+1.
  - `push` lasts exactly one cycle.
  - Result flags and `decided` hold from n+1 until the cycle after `clear`.
- **Window open.** `leds_on` rising at cycle n puts the block in ARMED at n+1. An edge at cycle n is therefore still judged as a false start.
- **Timeout.** `push` goes high one cycle after the TIMEOUT-th `slowen` tick in ARMED.
- **Clear.** `clear` at cycle n: outputs are 0 and state is IDLE at n+1. An edge at n+1 is arbitrated normally.
- **Throughput.** At most one `push` per round. A new decision needs `clear` first.

## Test plan
- **Right wins.** Reset, `leds_on`=1, then `pbr` rises 5 cycles later → `push` one cycle after the edge, `right`=1, `tie`=0, `fault`=0, `decided`=1 held.
- **Simultaneous press.** ARMED, `pbl` and `pbr` rise in the same cycle → `push`, `tie`=1, `right`=0, `fault`=0.
- **False start.** `leds_on`=0, `pbl` rises → `push`, `right`=1, `fault`=1. Later `leds_on` and further presses → no change and no second `push` until `clear`.
- **Held button.** `pbl` held through reset and into ARMED → no decision. `pbr` then rises → `right`=1.
- **Timeout.** TIMEOUT=3, ARMED, no presses, 3 `slowen` pulses → `push` with `tie`=1, `fault`=0. Also: `leds_on` falls before the 3rd tick → IDLE with no `push`.
- **Clear collision.** `clear` in the same cycle as a winning edge → no `push`, all flags 0, state IDLE. Next-cycle edge is arbitrated. Also: `rst` asserted in DONE → all outputs 0 next cycle.
